// File: rtl/muldiv_sequencer_if.sv
// Interface bundling the EX-stage request, flush, and result/status signals of
// the multiply/divide sequencer.
//   master : EX-stage side; drives ex_valid, Opcode, Function, rs_data, rt_data, flush
//   slave  : sequencer side; drives stall, busy, done, hilo_rdata, hi, lo
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ex_valid;
  logic [5:0]       Opcode;
  logic [5:0]       Function;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hilo_rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output ex_valid, Opcode, Function, rs_data, rt_data, flush,
    input  stall, busy, done, hilo_rdata, hi, lo
  );

  modport slave (
    input  ex_valid, Opcode, Function, rs_data, rt_data, flush,
    output stall, busy, done, hilo_rdata, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS multiply/divide sequencer for the EX stage. Decodes the R-type
// mult/multu/div/divu/mfhi/mthi/mflo/mtlo instructions, runs a shared shift-add /
// restoring-divide datapath for WIDTH iterations, owns HI/LO and stalls the pipe
// on HI/LO hazards while an operation is in flight.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : muldiv_sequencer_if.slave (request inputs, flush, stall/busy/done, HI/LO)
// Optional: define MULDIV_EARLY_TERM_EN to end a multiply as soon as the remaining
// multiplier bits are zero (divide latency is unaffected).
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  muldiv_sequencer_if.slave    bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StSign} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  // Multiply: product accumulator. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  // Multiply: left-shifting multiplicand. Divide: divisor in the low half.
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;   // negate product / quotient
  logic                 neg_hi_q, neg_hi_d;   // negate remainder
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  // Decode
  logic is_r, op_mult, op_multu, op_div, op_divu, op_mfhi, op_mthi, op_mflo, op_mtlo;
  logic is_md, is_hilo, start;
  assign is_r     = bus.ex_valid && (bus.Opcode == 6'd0);
  assign op_mult  = is_r && (bus.Function == 6'd24);
  assign op_multu = is_r && (bus.Function == 6'd25);
  assign op_div   = is_r && (bus.Function == 6'd26);
  assign op_divu  = is_r && (bus.Function == 6'd27);
  assign op_mfhi  = is_r && (bus.Function == 6'd16);
  assign op_mthi  = is_r && (bus.Function == 6'd17);
  assign op_mflo  = is_r && (bus.Function == 6'd18);
  assign op_mtlo  = is_r && (bus.Function == 6'd19);
  assign is_md    = op_mult || op_multu || op_div || op_divu;
  assign is_hilo  = is_md || op_mfhi || op_mthi || op_mflo || op_mtlo;
  assign start    = is_md && (state_q == StIdle) && !bus.flush;

  // Operand magnitudes and signs
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  assign rs_neg = (op_mult || op_div) && bus.rs_data[WIDTH-1];
  assign rt_neg = (op_mult || op_div) && bus.rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_mag = rt_neg ? -bus.rt_data : bus.rt_data;

  // Restoring divide step: shift in the next dividend bit, trial-subtract the divisor.
  logic [WIDTH:0] rem_sh, diff;
  assign rem_sh = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};

  // Sign correction applied in StSign
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_lo_q ? -prod_q : prod_q;
  assign quo_fix  = neg_lo_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_div_d = op_div || op_divu;
          count_d  = CW'(WIDTH);
          state_d  = StRun;
          if (op_div || op_divu) begin
            // A zero divisor yields an all-ones quotient; keep it un-negated.
            neg_lo_d = (rs_neg ^ rt_neg) && (bus.rt_data != '0);
            neg_hi_d = rs_neg;
            prod_d   = {{WIDTH{1'b0}}, rs_mag};
            mcand_d  = {{WIDTH{1'b0}}, rt_mag};
          end else begin
            neg_lo_d = rs_neg ^ rt_neg;
            neg_hi_d = 1'b0;
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, rs_mag};
            mplier_d = rt_mag;
`ifdef MULDIV_EARLY_TERM_EN
            if (rt_mag == '0) state_d = StSign;
`endif
          end
        end else begin
          if (op_mthi) hi_d = bus.rs_data;
          if (op_mtlo) lo_d = bus.rs_data;
        end
      end
      StRun: begin
        count_d = count_q - CW'(1);
        if (is_div_q) begin
          if (!diff[WIDTH]) prod_d = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
          else              prod_d = {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        end else begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (count_q == CW'(1)) state_d = StSign;
`ifdef MULDIV_EARLY_TERM_EN
        // Multiplicand is pre-shifted, so no outstanding shift remains to apply.
        if (!is_div_q && ((mplier_q >> 1) == '0)) state_d = StSign;
`endif
      end
      StSign: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush squashes an in-flight op, including its writeback.
    if (bus.flush && (state_q != StIdle)) begin
      state_d = StIdle;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.stall      = is_hilo && (state_q != StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.hilo_rdata = op_mfhi ? hi_q : (op_mflo ? lo_q : '0);
endmodule
